// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: decoded-instruction intake, register-file read,
// writeback retire and execute handoff, with status outputs.
interface operand_fetch_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic [4:0]      i_rd_addr;
  logic            i_rd_wen;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_pc;
  logic [4:0]      o_rs1_raddr;
  logic [4:0]      o_rs2_raddr;
  logic [XLEN-1:0] i_rs1_rdata;
  logic [XLEN-1:0] i_rs2_rdata;
  logic            i_wb_valid;
  logic [4:0]      i_wb_addr;
  logic [XLEN-1:0] i_wb_data;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wen;
  logic            o_stall;
  logic [31:0]     o_stall_cnt;

  modport slave (
    input  i_valid, i_rs1_addr, i_rs2_addr,
    input  i_rd_addr, i_rd_wen, i_imm, i_pc,
    input  i_rs1_rdata, i_rs2_rdata,
    input  i_wb_valid, i_wb_addr, i_wb_data,
    input  i_ready,
    output o_ready, o_rs1_raddr, o_rs2_raddr,
    output o_valid, o_rs1_data, o_rs2_data,
    output o_imm, o_pc, o_rd_addr, o_rd_wen,
    output o_stall, o_stall_cnt
  );

  modport master (
    output i_valid, i_rs1_addr, i_rs2_addr,
    output i_rd_addr, i_rd_wen, i_imm, i_pc,
    output i_rs1_rdata, i_rs2_rdata,
    output i_wb_valid, i_wb_addr, i_wb_data,
    output i_ready,
    input  o_ready, o_rs1_raddr, o_rs2_raddr,
    input  o_valid, o_rs1_data, o_rs2_data,
    input  o_imm, o_pc, o_rd_addr, o_rd_wen,
    input  o_stall, o_stall_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage with RAW scoreboard and registered execute handoff.
// Define OPERAND_FETCH_WB_BYPASS_EN to forward same-cycle writeback data.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rstn,
  operand_fetch_if.slave fb
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     busy_q, busy_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic            wen_q, wen_d;

  logic            byp1, byp2;
  logic            haz1, haz2, hazard;
  logic            ready, accept, stall;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  assign byp1 = fb.i_wb_valid
             && (fb.i_wb_addr != 5'd0)
             && (fb.i_wb_addr == fb.i_rs1_addr);
  assign byp2 = fb.i_wb_valid
             && (fb.i_wb_addr != 5'd0)
             && (fb.i_wb_addr == fb.i_rs2_addr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_sel = byp1 ? fb.i_wb_data
                        : fb.i_rs1_rdata;
  assign rs2_sel = byp2 ? fb.i_wb_data
                        : fb.i_rs2_rdata;

  assign haz1 = (fb.i_rs1_addr != 5'd0)
             && busy_q[fb.i_rs1_addr]
             && !byp1;
  assign haz2 = (fb.i_rs2_addr != 5'd0)
             && busy_q[fb.i_rs2_addr]
             && !byp2;
  assign hazard = haz1 || haz2;

  assign ready  = !hazard
               && ((state_q == EMPTY) || fb.i_ready);
  assign accept = fb.i_valid && ready;
  assign stall  = fb.i_valid && hazard;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (fb.i_ready && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    imm_d = imm_q;
    pc_d  = pc_q;
    rd_d  = rd_q;
    wen_d = wen_q;
    if (accept) begin
      rs1_d = rs1_sel;
      rs2_d = rs2_sel;
      imm_d = fb.i_imm;
      pc_d  = fb.i_pc;
      rd_d  = fb.i_rd_addr;
      wen_d = fb.i_rd_wen;
    end
  end

  // Clear first so a coinciding set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (fb.i_wb_valid && (fb.i_wb_addr != 5'd0))
      busy_d[fb.i_wb_addr] = 1'b0;
    if (accept && fb.i_rd_wen
        && (fb.i_rd_addr != 5'd0))
      busy_d[fb.i_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      busy_q  <= '0;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  assign fb.o_rs1_raddr = fb.i_rs1_addr;
  assign fb.o_rs2_raddr = fb.i_rs2_addr;
  assign fb.o_ready     = ready;
  assign fb.o_stall     = stall;
  assign fb.o_stall_cnt = cnt_q;
  assign fb.o_valid     = (state_q == FULL);
  assign fb.o_rs1_data  = rs1_q;
  assign fb.o_rs2_data  = rs2_q;
  assign fb.o_imm       = imm_q;
  assign fb.o_pc        = pc_q;
  assign fb.o_rd_addr   = rd_q;
  assign fb.o_rd_wen    = wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: handshake, scoreboard,
// stall counting, backpressure and async reset.
module tb_operand_fetch;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;
  logic [31:0] exp_cnt;

  operand_fetch_if #(.XLEN(32)) bus ();

  operand_fetch #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic        wen,
    input logic [31:0] pc
  );
    bus.i_valid    = 1'b1;
    bus.i_rs1_addr = rs1;
    bus.i_rs2_addr = rs2;
    bus.i_rd_addr  = rd;
    bus.i_rd_wen   = wen;
    bus.i_pc       = pc;
    bus.i_imm      = pc + 32'd4;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_cnt = 0;
    rstn = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_rs1_addr  = '0;
    bus.i_rs2_addr  = '0;
    bus.i_rd_addr   = '0;
    bus.i_rd_wen    = 1'b0;
    bus.i_imm       = '0;
    bus.i_pc        = '0;
    bus.i_rs1_rdata = '0;
    bus.i_rs2_rdata = '0;
    bus.i_wb_valid  = 1'b0;
    bus.i_wb_addr   = '0;
    bus.i_wb_data   = '0;
    bus.i_ready     = 1'b1;

    // reset state
    #12;
    check("rst_valid", bus.o_valid, 0);
    check("rst_cnt", bus.o_stall_cnt, 0);
    check("rst_rs1", bus.o_rs1_data, 0);
    check("rst_pc", bus.o_pc, 0);
    check("rst_busy", dut.busy_q, 0);
    @(negedge clk);
    rstn = 1'b1;

    // basic accept
    put(5'd1, 5'd2, 5'd3, 1'b1, 32'h40);
    bus.i_rs1_rdata = 32'd5;
    bus.i_rs2_rdata = 32'd7;
    #1;
    check("first_ready", bus.o_ready, 1);
    check("raddr1", bus.o_rs1_raddr, 1);
    check("raddr2", bus.o_rs2_raddr, 2);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check("add_valid", bus.o_valid, 1);
    check("add_rs1", bus.o_rs1_data, 5);
    check("add_rs2", bus.o_rs2_data, 7);
    check("add_rd", bus.o_rd_addr, 3);
    check("add_imm", bus.o_imm, 32'h44);
    check("add_busy3", dut.busy_q[3], 1);

    // RAW stall on x3
    put(5'd3, 5'd0, 5'd0, 1'b0, 32'h50);
    bus.i_rs1_rdata = 32'h33;
    #1;
    check("raw_ready", bus.o_ready, 0);
    check("raw_stall", bus.o_stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cnt++;
      check("raw_stall_hold", bus.o_stall, 1);
      check("raw_cnt", bus.o_stall_cnt, exp_cnt);
    end
    check("raw_drained", bus.o_valid, 0);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd3;
    bus.i_wb_data  = 32'h99;
    #1;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    check("byp_nostall", bus.o_stall, 0);
    check("byp_ready", bus.o_ready, 1);
    tick();
    bus.i_wb_valid = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("byp_valid", bus.o_valid, 1);
    check("byp_rs1", bus.o_rs1_data, 32'h99);
`else
    check("wb_still_stall", bus.o_stall, 1);
    tick();
    exp_cnt++;
    bus.i_wb_valid = 1'b0;
    #1;
    check("wb_ready", bus.o_ready, 1);
    check("wb_nostall", bus.o_stall, 0);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check("wb_valid", bus.o_valid, 1);
    check("wb_rs1", bus.o_rs1_data, 32'h33);
`endif
    check("wb_cnt", bus.o_stall_cnt, exp_cnt);
    check("wb_busy", dut.busy_q, 0);

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // same-cycle writeback forwarded
    put(5'd0, 5'd0, 5'd3, 1'b1, 32'h60);
    tick();
    put(5'd3, 5'd0, 5'd0, 1'b0, 32'h64);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd3;
    bus.i_wb_data  = 32'hDEAD;
    #1;
    check("dead_nostall", bus.o_stall, 0);
    tick();
    bus.i_valid = 1'b0;
    bus.i_wb_valid = 1'b0;
    #1;
    check("dead_rs1", bus.o_rs1_data, 32'hDEAD);
    check("dead_cnt", bus.o_stall_cnt, exp_cnt);
`endif

    // backpressure
    put(5'd4, 5'd6, 5'd0, 1'b0, 32'h100);
    tick();
    bus.i_ready = 1'b0;
    put(5'd4, 5'd6, 5'd0, 1'b0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", bus.o_valid, 1);
      check("bp_pc", bus.o_pc, 32'h100);
      check("bp_ready", bus.o_ready, 0);
      tick();
    end
    bus.i_ready = 1'b1;
    #1;
    check("bp_release", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check("bp_newpc", bus.o_pc, 32'h200);

    // set wins over coinciding clear
    put(5'd0, 5'd0, 5'd5, 1'b1, 32'h300);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd5;
    tick();
    bus.i_wb_valid = 1'b0;
    #1;
    check("setwin_busy", dut.busy_q, 32'h20);
    put(5'd0, 5'd0, 5'd0, 1'b1, 32'h304);
    #1;
    check("x0_nostall", bus.o_stall, 0);
    check("x0_ready", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = 5'd0;
    #1;
    check("x0_busy", dut.busy_q, 32'h20);
    tick();
    bus.i_wb_valid = 1'b0;
    #1;
    check("wb0_busy", dut.busy_q, 32'h20);
    check("pre_rst_full", bus.o_valid, 1);
    check("pre_rst_cnt", bus.o_stall_cnt, exp_cnt);

    // async reset mid-cycle
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", bus.o_valid, 0);
    check("arst_busy", dut.busy_q, 0);
    check("arst_cnt", bus.o_stall_cnt, 0);
    check("arst_rd", bus.o_rd_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    bus.i_ready = 1'b1;
    put(5'd5, 5'd0, 5'd1, 1'b1, 32'h400);
    #1;
    check("post_ready", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check("post_valid", bus.o_valid, 1);
    check("post_pc", bus.o_pc, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
